// File: rtl/skew_feeder.sv
// skew_feeder
// -----------
// Reads LANES upstream buffers and presents their words to the west edge of
// a systolic array with a diagonal skew: lane i starts one cycle after lane
// i-1, so row i of the array sees its first operand one cycle later than row
// i-1. Each pass issues exactly VECLEN reads per lane. Lanes that carry no
// word in a given cycle output zero, which is the padding the array expects.
//
// Sequencing: IDLE -> RUN (VECLEN+LANES-1 cycles) -> DRAIN (2 cycles) -> IDLE.
// DRAIN lets the two-stage data pipeline empty before done is pulsed.
// CNTW must satisfy 2**CNTW >= VECLEN+LANES.
//
// Ports
//   clk        clock, rising edge
//   rstn       synchronous active-low reset
//   start      begin one pass (only looked at in IDLE with hold low)
//   hold       downstream stall; freezes every register, forces rd_en low
//   rd_en      per-lane read strobe to the upstream buffers (combinational)
//   buf_dout   buffer read data, lane i at [i*WORDLEN +: WORDLEN],
//              valid the cycle after rd_en[i]
//   arr_dout   skewed data to the array, same lane packing, 0 when invalid
//   arr_valid  per-lane qualifier for arr_dout
//   busy       high in RUN and DRAIN
//   done       one-cycle pulse on the first IDLE cycle after a pass
module skew_feeder #(
    parameter int WORDLEN = 8,
    parameter int LANES   = 4,
    parameter int VECLEN  = 16,
    parameter int CNTW    = 5
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       hold,
    output logic [LANES-1:0]           rd_en,
    input  logic [LANES*WORDLEN-1:0]   buf_dout,
    output logic [LANES*WORDLEN-1:0]   arr_dout,
    output logic [LANES-1:0]           arr_valid,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Last RUN count: the read window of the final lane closes here.
    localparam logic [CNTW-1:0] LAST = CNTW'(VECLEN + LANES - 2);

    state_t                     state_q;
    logic [CNTW-1:0]            cyc_q;
    logic                       drn_q;
    logic [LANES-1:0]           v1_q;
    logic [LANES-1:0]           valid_q;
    logic [LANES*WORDLEN-1:0]   dout_q;
    logic [LANES*WORDLEN-1:0]   dout_d;
    logic                       done_q;

    // Per-lane read window and output masking. Lane i reads while
    // i <= cyc <= i+VECLEN-1, which produces the one-cycle stagger.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int LO = g;
        localparam int HI = g + VECLEN - 1;

        assign rd_en[g] = (state_q == RUN) && !hold &&
                          (int'(cyc_q) >= LO) && (int'(cyc_q) <= HI);

        // Stale buffer output is masked so idle lanes feed zeros.
        assign dout_d[g*WORDLEN +: WORDLEN] =
            v1_q[g] ? buf_dout[g*WORDLEN +: WORDLEN] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            drn_q   <= 1'b0;
            v1_q    <= '0;
            valid_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else if (!hold) begin
            // Stage 1 remembers which lanes were read; stage 2 captures the
            // buffer data that arrives one cycle after the read.
            v1_q    <= rd_en;
            valid_q <= v1_q;
            dout_q  <= dout_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cyc_q   <= '0;
                    end
                end
                RUN: begin
                    if (cyc_q == LAST) begin
                        state_q <= DRAIN;
                        drn_q   <= 1'b0;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drn_q) begin
                        state_q <= IDLE;
                        drn_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drn_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arr_dout  = dout_q;
    assign arr_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
